// File: rtl/mips_main_control.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/mem/writeback and drives datapath selects.
// Latency: outputs decode the current state combinationally; IRWrite/PCWrite in FETCH follow mem_ready (Mealy).
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; mem_ready is ignored in all other states.
module mips_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondN,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic [5:0] ALUOP,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_FUNC = 6'b000010;
  localparam logic [5:0] ALU_AND  = 6'b000011;
  localparam logic [5:0] ALU_OR   = 6'b000100;
  localparam logic [5:0] ALU_SLT  = 6'b000101;

  state_t cur, nxt;

  always_comb begin
    nxt          = cur;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    PCWriteCondN = 1'b0;
    PCSource     = 2'b00;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ExtZero      = 1'b0;
    ALUOP        = ALU_ADD;
    illegal_op   = 1'b0;

    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                     nxt = S_MEMADR;
          OP_RTYPE:                         nxt = S_RTYPEEX;
          OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_IMMEX;
          OP_J:                             nxt = S_JUMP;
          default: begin
            nxt        = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOP   = ALU_FUNC;
        nxt     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOP        = ALU_SUB;
        PCSource     = 2'b01;
        PCWriteCond  = (opcode == OP_BEQ);
        PCWriteCondN = (opcode == OP_BNE);
        nxt          = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode)
          OP_ANDI: begin ALUOP = ALU_AND; ExtZero = 1'b1; end
          OP_ORI:  begin ALUOP = ALU_OR;  ExtZero = 1'b1; end
          OP_SLTI: ALUOP = ALU_SLT;
          default: ALUOP = ALU_ADD;
        endcase
        nxt = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        nxt      = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    // Reset silences every strobe immediately, so an abandoned instruction never commits
    if (!rst_n) begin
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      PCWriteCondN = 1'b0;
      PCSource     = 2'b00;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b01;
      ExtZero      = 1'b0;
      ALUOP        = ALU_ADD;
      illegal_op   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  assign state = cur;

endmodule

// File: tb/tb_mips_main_control.sv
// Bench for mips_main_control: per-instruction cycle scripts feed an expected-output queue,
// a negedge monitor pops one record per cycle and compares it with the DUT outputs.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, ExtZero, illegal_op;
  logic [1:0] PCSource, ALUSrcB;
  logic [5:0] ALUOP;
  logic [3:0] state;

  mips_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondN(PCWriteCondN),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtZero(ExtZero), .ALUOP(ALUOP),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, pcwcn;
    logic [1:0] pcs;
    logic       iord, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb;
    logic       ext;
    logic [5:0] aluop;
    logic       ill;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic rec_t mk(input int st);
    rec_t r;
    r    = '0;
    r.st = 4'(st);
    return r;
  endfunction

  function automatic rec_t rst_rec(input int st);
    rec_t r;
    r     = mk(st);
    r.asb = 2'b01;
    return r;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // One cycle of stimulus plus the outputs that cycle must show
  task automatic cyc(input logic [5:0] op, input logic mr, input logic rs, input rec_t r);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    rst_n     = rs;
    exp_q.push_back(r);
  endtask

  task automatic fetch(input int fw);
    rec_t r;
    for (int i = 0; i < fw; i++) begin
      r = mk(0); r.mrd = 1; r.asb = 2'b01;
      cyc(6'($urandom), 1'b0, 1'b1, r);
    end
    r = mk(0); r.mrd = 1; r.asb = 2'b01; r.irw = 1; r.pcw = 1;
    cyc(6'($urandom), 1'b1, 1'b1, r);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from fetch to its last cycle
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit rst_mid);
    rec_t r;
    fetch(fw);
    r = mk(1); r.asb = 2'b11; r.ill = !is_legal(op);
    cyc(op, rbit(), 1'b1, r);
    case (op)
      6'b100011, 6'b101011: begin
        r = mk(2); r.asa = 1; r.asb = 2'b10;
        cyc(op, rbit(), 1'b1, r);
        if (op == 6'b100011) begin
          if (rst_mid) begin
            cyc(op, rbit(), 1'b0, rst_rec(3));
            return;
          end
          for (int i = 0; i <= mw; i++) begin
            r = mk(3); r.mrd = 1; r.iord = 1;
            cyc(op, (i == mw), 1'b1, r);
          end
          r = mk(4); r.rw = 1; r.m2r = 1;
          cyc(op, rbit(), 1'b1, r);
        end else begin
          for (int i = 0; i <= mw; i++) begin
            r = mk(5); r.mwr = 1; r.iord = 1;
            cyc(op, (i == mw), 1'b1, r);
          end
        end
      end
      6'b000000: begin
        r = mk(6); r.asa = 1; r.aluop = 6'd2;
        cyc(op, rbit(), 1'b1, r);
        r = mk(7); r.rw = 1; r.rdst = 1;
        cyc(op, rbit(), 1'b1, r);
      end
      6'b000100, 6'b000101: begin
        r = mk(8); r.asa = 1; r.aluop = 6'd1; r.pcs = 2'b01;
        r.pcwc = (op == 6'b000100); r.pcwcn = (op == 6'b000101);
        cyc(op, rbit(), 1'b1, r);
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        r = mk(9); r.asa = 1; r.asb = 2'b10;
        if (op == 6'b001100) begin r.aluop = 6'd3; r.ext = 1; end
        if (op == 6'b001101) begin r.aluop = 6'd4; r.ext = 1; end
        if (op == 6'b001010) r.aluop = 6'd5;
        cyc(op, rbit(), 1'b1, r);
        r = mk(10); r.rw = 1;
        cyc(op, rbit(), 1'b1, r);
      end
      6'b000010: begin
        r = mk(11); r.pcw = 1; r.pcs = 2'b10;
        cyc(op, rbit(), 1'b1, r);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    rec_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.st = state; g.pcw = PCWrite; g.pcwc = PCWriteCond; g.pcwcn = PCWriteCondN;
      g.pcs = PCSource; g.iord = IorD; g.mrd = MemRead; g.mwr = MemWrite; g.irw = IRWrite;
      g.rdst = RegDst; g.m2r = MemtoReg; g.rw = RegWrite; g.asa = ALUSrcA; g.asb = ALUSrcB;
      g.ext = ExtZero; g.aluop = ALUOP; g.ill = illegal_op;
      checks++;
      if (g === e) passed++;
      else $display("FAIL outputs exp_state=%0d got=%h want=%h (t=%0t)", e.st, g, e, $time);
    end
  end

  logic [5:0] ops[10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                          6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};

  initial begin
    logic [5:0] op;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b0;
    cyc(6'b0, 1'b1, 1'b0, rst_rec(0));
    cyc(6'b0, 1'b1, 1'b0, rst_rec(0));
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b100011, 0, 2, 1'b0);
    run_instr(6'b000100, 3, 0, 1'b0);
    run_instr(6'b001100, 0, 0, 1'b0);
    run_instr(6'b001010, 0, 0, 1'b0);
    run_instr(6'b101011, 0, 0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(6'b100011, 1, 0, 1'b1);
    run_instr(6'b000101, 0, 0, 1'b0);
    run_instr(6'b001101, 2, 0, 1'b0);
    run_instr(6'b001000, 0, 0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(9)];
      run_instr(op, $urandom_range(3), $urandom_range(3), ($urandom_range(19) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain leftover=%0d want=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mips_main_control.md
# mips_main_control

Multicycle MIPS main controller: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every datapath strobe and mux select. It also produces the 6-bit `ALUOP` code consumed by the ALU control decoder, which in turn combines `ALUOP` with `funct` to select the ALU operation. It stalls on a memory-ready handshake, so a variable-latency memory can sit behind the datapath.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — single system clock; all state changes on rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `opcode` in 6 — IR[31:26]; stable from the cycle after `IRWrite` until the next fetch.
- `mem_ready` in 1 — memory completed the current read or write this cycle.
- `PCWrite` out 1 — unconditional PC load.
- `PCWriteCond` out 1 — PC load if ALU `zero`=1 (beq).
- `PCWriteCondN` out 1 — PC load if ALU `zero`=0 (bne).
- `PCSource` out 2 — 00 ALU result, 01 ALUOut (branch target), 10 jump address.
- `IorD` out 1 — memory address: 0 = PC, 1 = ALUOut.
- `MemRead` out 1 — memory read strobe.
- `MemWrite` out 1 — memory write strobe.
- `IRWrite` out 1 — instruction register load.
- `RegDst` out 1 — write register: 0 = rt, 1 = rd.
- `MemtoReg` out 1 — write data: 0 = ALUOut, 1 = MDR.
- `RegWrite` out 1 — register file write.
- `ALUSrcA` out 1 — ALU operand A: 0 = PC, 1 = A register.
- `ALUSrcB` out 2 — ALU operand B: 00 = B register, 01 = 4, 10 = sign/zero-extended immediate, 11 = sign-extended immediate << 2.
- `ExtZero` out 1 — zero-extend the immediate (andi/ori).
- `ALUOP` out 6 — 000000 add, 000001 sub, 000010 R-type (decode `funct`), 000011 and, 000100 or, 000101 slt.
- `illegal_op` out 1 — one-cycle pulse on an unsupported opcode.
- `state` out 4 — current state, for debug.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - RTYPEEX=6, RTYPEWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11.
- Unlisted outputs are 0 in every state. Default values: `ALUOP`=000000, `ALUSrcB`=00, `PCSource`=00.
- **FETCH:** `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOP`=add.
  - `IRWrite`=`PCWrite`=`mem_ready` (Mealy).
  - Hold in FETCH while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- **DECODE:** `ALUSrcA`=0, `ALUSrcB`=11, `ALUOP`=add (precomputes the branch target). Next state by opcode:
  - 100011 (lw) / 101011 (sw) → MEMADR.
  - 000000 → RTYPEEX.
  - 000100 / 000101 → BRANCH.
  - 001000 / 001100 / 001101 / 001010 → IMMEX.
  - 000010 → JUMP.
  - Any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- **MEMADR:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUOP`=add. Next: lw → MEMRD, sw → MEMWR.
- **MEMRD:** `MemRead`=1, `IorD`=1. Hold until `mem_ready`, then → MEMWB.
- **MEMWB:** `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Next → FETCH.
- **MEMWR:** `MemWrite`=1, `IorD`=1. Hold until `mem_ready`, then → FETCH.
- **RTYPEEX:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUOP`=000010. Next → RTYPEWB.
- **RTYPEWB:** `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next → FETCH.
- **BRANCH:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUOP`=sub, `PCSource`=01.
  - beq asserts `PCWriteCond`=1; bne asserts `PCWriteCondN`=1.
  - Next → FETCH.
- **IMMEX:** `ALUSrcA`=1, `ALUSrcB`=10. Per opcode:
  - addi: `ALUOP`=add.
  - andi: `ALUOP`=and, `ExtZero`=1.
  - ori: `ALUOP`=or, `ExtZero`=1.
  - slti: `ALUOP`=slt.
  - Next → IMMWB.
- **IMMWB:** `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next → FETCH.
- **JUMP:** `PCWrite`=1, `PCSource`=10. Next → FETCH.
- Any unencoded state value (12–15) → FETCH on the next edge, with all strobes 0 in that cycle.

## Timing
- **Reset:**
  - While `rst_n`=0 at a rising edge, `state` becomes FETCH.
  - While `rst_n` is low, the strobes `PCWrite`, `PCWriteCond`, `PCWriteCondN`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite` and `illegal_op` are forced to 0. Selects take their FETCH values.
  - Reset mid-instruction abandons the instruction; no strobe is issued in the reset cycle.
- First fetch: `MemRead`=1 in the first cycle after `rst_n` goes high.
- Cycles per instruction with zero memory wait (every `mem_ready` sampled 1):
  - lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is ignored in every other state.
- Strobes are level signals valid for the whole cycle. Each write strobe is high for exactly one cycle per instruction (`IRWrite`/`PCWrite` in FETCH only on the ready cycle).
- `MemRead` and `MemWrite` are never high in the same cycle.

## Test plan
- **Reset then R-type:** `rst_n`=0 for 2 cycles, `mem_ready`=1, `opcode`=000000.
  - `state` sequence 0,1,6,7,0.
  - `ALUOP`=000010 in state 6; `RegWrite`=`RegDst`=1 in state 7.
- **lw with 2-cycle read wait:** `opcode`=100011, `mem_ready` low for 2 cycles in MEMRD.
  - Sequence 0,1,2,3,3,3,4,0.
  - `IorD`=1 throughout MEMRD; `MemtoReg`=1 in MEMWB.
- **Fetch stall then beq:** `mem_ready`=0 for 3 cycles in FETCH, `opcode`=000100.
  - `IRWrite`/`PCWrite` stay 0 for 3 cycles, then pulse once.
  - BRANCH shows `ALUOP`=000001, `PCWriteCond`=1, `PCWriteCondN`=0, `PCSource`=01.
- **Immediate opcodes:** andi (001100) then slti (001010).
  - andi: IMMEX gives `ALUOP`=000011, `ExtZero`=1.
  - slti: IMMEX gives `ALUOP`=000101, `ExtZero`=0.
  - IMMWB gives `RegWrite`=1, `RegDst`=0 for both.
- **sw, then j:**
  - sw (101011): `MemWrite`=1 in state 5, then → FETCH after 4 cycles.
  - j (000010): state 11 with `PCWrite`=1, `PCSource`=10.
- **Illegal opcode and reset mid-instruction:**
  - `opcode`=111111: `illegal_op`=1 in DECODE only, then → FETCH.
  - Reset asserted in MEMRD: next state FETCH, with no `RegWrite` pulse.
